// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access, one transaction at a time.
// Latency: grant at the edge a request is seen; completion is combinational with mem_ack (2 cycles minimum).
// Backpressure: requesters hold req (stalled) until their valid pulse; a hung memory is aborted after TIMEOUT cycles.
module mem_port_arbiter #(
   parameter int MAX_IF_WAIT = 4,
   parameter int TIMEOUT     = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [3:0]  dm_wstrb,
   output logic [31:0] dm_rdata,
   output logic        dm_valid,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        bus_err
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BUSY_IF = 2'd1;
   localparam logic [1:0] BUSY_DM = 2'd2;

   localparam int SW = $clog2(MAX_IF_WAIT + 1);
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_IF_WAIT);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

   logic [1:0]    state;
   logic [SW-1:0] starve;
   logic [TW-1:0] tcnt;
   logic          busy;
   logic          timeout_hit;
   logic          done;
   logic          conflict;
   logic          if_wins;
   logic          grant_if;
   logic          grant_dm;

   assign busy        = (state != IDLE);
   // ack on the last allowed cycle still counts as a normal completion
   assign timeout_hit = busy & ~mem_ack & (tcnt == TMO_LAST);
   assign done        = busy & (mem_ack | timeout_hit);

   // DM has priority unless fetch has already lost MAX_IF_WAIT conflicts in a row
   assign conflict = if_req & dm_req;
   assign if_wins  = if_req & (~dm_req | (starve == STARVE_MAX));
   assign grant_if = (state == IDLE) & if_wins;
   assign grant_dm = (state == IDLE) & dm_req & ~if_wins;

   assign if_valid  = (state == BUSY_IF) & done;
   assign dm_valid  = (state == BUSY_DM) & done;
   // an aborted transaction returns zero data
   assign if_rdata  = (if_valid & mem_ack) ? mem_rdata : '0;
   assign dm_rdata  = (dm_valid & mem_ack) ? mem_rdata : '0;
   assign bus_err   = timeout_hit;
   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = dm_req & ~dm_valid;

   // arbitration FSM: grant from IDLE, return to IDLE on ack or abort
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (grant_if)
                  state <= BUSY_IF;
               else if (grant_dm)
                  state <= BUSY_DM;
            end
            default: begin
               if (done)
                  state <= IDLE;
            end
         endcase
      end
   end

   // memory-side request registers, captured from the winner and held until completion
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else if (grant_if) begin
         mem_req   <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= if_addr & 32'hFFFF_FFFC;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else if (grant_dm) begin
         mem_req   <= 1'b1;
         mem_we    <= dm_we;
         mem_addr  <= dm_addr & 32'hFFFF_FFFC;
         mem_wdata <= dm_wdata;
         mem_wstrb <= dm_we ? dm_wstrb : 4'b0000;
      end else if (done) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_wstrb <= '0;
      end
   end

   // count conflicts lost by fetch; any fetch grant clears the count
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         starve <= '0;
      else if (grant_if)
         starve <= '0;
      else if (grant_dm & conflict & (starve != STARVE_MAX))
         starve <= starve + 1'b1;
   end

   // busy-cycle counter for the hung-memory abort
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tcnt <= '0;
      else if (~busy | done)
         tcnt <= '0;
      else
         tcnt <= tcnt + 1'b1;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all against a transaction-level model.
// Latency: model tracks owner, busy-cycle count and starvation count as plain integers.
// Backpressure: requesters hold requests until their valid pulse, then choose a new one.
module tb_mem_port_arbiter;

   localparam int MAX_IF_WAIT = 4;
   localparam int TIMEOUT     = 16;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_wstrb;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        stall_if;
   logic        stall_mem;
   logic        bus_err;

   mem_port_arbiter #(.MAX_IF_WAIT(MAX_IF_WAIT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: 0 = no transaction, 1 = fetch owns memory, 2 = data owns memory
   int          m_owner  = 0;
   int          m_cycles = 0;   // busy cycles already completed without ack
   int          m_starve = 0;
   logic [31:0] m_addr   = '0;
   logic [31:0] m_wdata  = '0;
   logic        m_we     = 1'b0;
   logic [3:0]  m_wstrb  = '0;
   bit          hang     = 1'b0;
   bit          last_ifv = 1'b0;
   bit          last_dmv = 1'b0;
   int          ifv_cnt  = 0;
   int          dmv_cnt  = 0;
   int          berr_cnt = 0;
   logic [31:0] grants_q[$];

   task automatic model_reset();
      m_owner  = 0;
      m_cycles = 0;
      m_starve = 0;
      last_ifv = 1'b0;
      last_dmv = 1'b0;
   endtask

   task automatic grant_fetch();
      m_owner  = 1;
      m_cycles = 0;
      m_addr   = if_addr & 32'hFFFF_FFFC;
      m_we     = 1'b0;
      m_wstrb  = 4'b0000;
      m_starve = 0;
      hang     = ($urandom % 6) == 0;
   endtask

   task automatic grant_data();
      m_owner  = 2;
      m_cycles = 0;
      m_addr   = dm_addr & 32'hFFFF_FFFC;
      m_we     = dm_we;
      m_wdata  = dm_wdata;
      m_wstrb  = dm_we ? dm_wstrb : 4'b0000;
      hang     = ($urandom % 6) == 0;
   endtask

   // one clock cycle: check outputs against the model for the driven inputs, then advance the model
   task automatic step();
      bit          busy, tmo, done, eifv, edmv;
      logic [31:0] eifr, edmr;
      #1;
      busy = (m_owner != 0);
      tmo  = busy && !mem_ack && (m_cycles + 1 == TIMEOUT);
      done = busy && (mem_ack || tmo);
      eifv = (m_owner == 1) && done;
      edmv = (m_owner == 2) && done;
      eifr = (eifv && mem_ack) ? mem_rdata : 32'h0;
      edmr = (edmv && mem_ack) ? mem_rdata : 32'h0;
      chk("mem_req", 32'(mem_req), 32'(busy));
      if (busy) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_we", 32'(mem_we), 32'(m_we));
         chk("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
         if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
         if (m_cycles == 0) grants_q.push_back(mem_addr);
      end
      chk("if_valid", 32'(if_valid), 32'(eifv));
      chk("dm_valid", 32'(dm_valid), 32'(edmv));
      chk("if_rdata", if_rdata, eifr);
      chk("dm_rdata", dm_rdata, edmr);
      chk("bus_err", 32'(bus_err), 32'(tmo));
      chk("stall_if", 32'(stall_if), 32'(if_req && !eifv));
      chk("stall_mem", 32'(stall_mem), 32'(dm_req && !edmv));
      if (if_valid) ifv_cnt++;
      if (dm_valid) dmv_cnt++;
      if (bus_err) berr_cnt++;
      last_ifv = eifv;
      last_dmv = edmv;
      @(posedge clk);
      #1;
      if (busy) begin
         if (done) m_owner = 0;
         else m_cycles++;
      end else if (if_req && dm_req) begin
         if (m_starve == MAX_IF_WAIT) begin
            grant_fetch();
         end else begin
            grant_data();
            if (m_starve < MAX_IF_WAIT) m_starve++;
         end
      end else if (if_req) begin
         grant_fetch();
      end else if (dm_req) begin
         grant_data();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
      chk("rst_if_valid", 32'(if_valid), 32'h0);
      chk("rst_dm_valid", 32'(dm_valid), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // requesters keep a pending request stable; memory acks randomly or hangs
   task automatic drive_random();
      if (!if_req || last_ifv) begin
         if_req  = ($urandom % 3) != 0;
         if_addr = $urandom;
      end
      if (!dm_req || last_dmv) begin
         dm_req   = ($urandom % 3) != 0;
         dm_we    = $urandom % 2;
         dm_addr  = $urandom;
         dm_wdata = $urandom;
         dm_wstrb = 4'($urandom);
      end
      mem_rdata = $urandom;
      if (m_owner != 0)
         mem_ack = hang ? ((m_cycles + 1 == TIMEOUT) && ($urandom % 2 == 1)) : ($urandom % 3 == 0);
      else
         mem_ack = $urandom % 2;
   endtask

   initial begin
      int d0, b0, i0;
      reset     = 1'b1;
      if_req    = 1'b0;
      if_addr   = '0;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      dm_addr   = '0;
      dm_wdata  = '0;
      dm_wstrb  = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      @(posedge clk);
      #1;
      do_reset();

      // single load with immediate ack
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0106;
      step();
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("ld_addr", mem_addr, 32'h0000_0104);
      chk("ld_wstrb", 32'(mem_wstrb), 32'h0);
      chk("ld_valid", 32'(dm_valid), 32'h1);
      chk("ld_rdata", dm_rdata, 32'hDEAD_BEEF);
      chk("ld_stall", 32'(stall_mem), 32'h0);
      step();
      dm_req = 1'b0; mem_ack = 1'b0;
      step();

      // store with ack delayed three cycles
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0202;
      dm_wdata = 32'h1234_5678; dm_wstrb = 4'b0011;
      step();
      d0 = dmv_cnt; b0 = berr_cnt;
      for (int i = 0; i < 4; i++) begin
         mem_ack = (i == 3); mem_rdata = $urandom;
         #1;
         chk("st_addr", mem_addr, 32'h0000_0200);
         chk("st_wdata", mem_wdata, 32'h1234_5678);
         chk("st_wstrb", 32'(mem_wstrb), 32'h3);
         chk("st_we", 32'(mem_we), 32'h1);
         step();
      end
      chk("st_pulses", 32'(dmv_cnt - d0), 32'h1);
      chk("st_berr", 32'(berr_cnt - b0), 32'h0);
      dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
      step();

      // continuous conflict: fetch wins every fifth grant
      grants_q.delete();
      if_req = 1'b1; if_addr = 32'h0000_1000;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_2000;
      for (int i = 0; i < 20; i++) begin
         mem_ack = (m_owner != 0);
         step();
      end
      chk("cf_grants", 32'(grants_q.size()), 32'd10);
      for (int i = 0; i < 10 && i < grants_q.size(); i++)
         chk($sformatf("cf_grant%0d", i), grants_q[i], (i % 5 == 4) ? 32'h0000_1000 : 32'h0000_2000);
      if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
      step();

      // fetch with memory never acking
      if_req = 1'b1; if_addr = 32'h0000_0040; mem_rdata = 32'hA5A5_A5A5;
      step();
      b0 = berr_cnt; i0 = ifv_cnt;
      for (int i = 1; i <= TIMEOUT; i++) begin
         if (i == TIMEOUT) begin
            #1;
            chk("to_valid", 32'(if_valid), 32'h1);
            chk("to_rdata", if_rdata, 32'h0);
            chk("to_berr", 32'(bus_err), 32'h1);
         end
         step();
      end
      chk("to_berr_once", 32'(berr_cnt - b0), 32'h1);
      chk("to_valid_once", 32'(ifv_cnt - i0), 32'h1);
      if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300;
      #1;
      chk("to_idle", 32'(mem_req), 32'h0);
      step();
      mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
      #1;
      chk("post_to_valid", 32'(dm_valid), 32'h1);
      chk("post_to_rdata", dm_rdata, 32'h1357_9BDF);
      step();
      dm_req = 1'b0; mem_ack = 1'b0;
      step();

      // ack arriving on the timeout cycle wins
      dm_req = 1'b1; dm_addr = 32'h0000_0400;
      step();
      for (int i = 1; i <= TIMEOUT; i++) begin
         mem_ack = (i == TIMEOUT); mem_rdata = 32'hCAFE_F00D;
         if (i == TIMEOUT) begin
            #1;
            chk("at_valid", 32'(dm_valid), 32'h1);
            chk("at_rdata", dm_rdata, 32'hCAFE_F00D);
            chk("at_berr", 32'(bus_err), 32'h0);
         end
         step();
      end
      dm_req = 1'b0; mem_ack = 1'b0;
      step();

      // reset in the middle of a data transaction
      dm_req = 1'b1; dm_addr = 32'h0000_0500;
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
      chk("mr_req", 32'(mem_req), 32'h0);
      chk("mr_valid", 32'(dm_valid), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      chk("mr_valid_hold", 32'(dm_valid), 32'h0);
      reset = 1'b0;
      d0 = dmv_cnt;
      step();
      for (int i = 0; i < 5; i++) begin
         mem_ack = (i == 4); mem_rdata = 32'h0BAD_F00D;
         step();
      end
      chk("mr_reissue", 32'(dmv_cnt - d0), 32'h1);
      dm_req = 1'b0; mem_ack = 1'b0;
      step();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         drive_random();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
